audio_rom_scheduler: RTL and testbench

// - Shares one single-port waveform ROM between the left and right DAC channels.
//   - Table 0 (rom_addr MSB=0) holds the base tone; table 1 (MSB=1) holds the harmony.
// - Once per audio frame (rising edge of lrck_dac) it advances two phase accumulators.
// - It then reads the ROM for L, then for R, and presents both samples together,

---
 rtl/audio_rom_scheduler_if.sv | 40 ++++
 rtl/audio_rom_scheduler.sv | 165 ++++++++++++++++
 tb/tb_audio_rom_scheduler.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/audio_rom_scheduler_if.sv
// Bundle of frame-clock, step, ROM and DAC-side signals for audio_rom_scheduler.
// The overrun_cnt member exists only when OVERRUN_CNT_EN is defined.
interface audio_rom_scheduler_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 24,
  parameter int ACC_W  = 16
);
  logic              lrck_dac;
  logic              enable;
  logic [ACC_W-1:0]  step_l;
  logic [ACC_W-1:0]  step_r;
  logic [ADDR_W:0]   rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic [DATA_W-1:0] data_dac_chL;
  logic [DATA_W-1:0] data_dac_chR;
  logic              frame_done;
  logic              busy;
  logic              overrun;
`ifdef OVERRUN_CNT_EN
  logic [7:0]        overrun_cnt;

  modport master (
    input  lrck_dac, enable, step_l, step_r, rom_q,
    output rom_addr, data_dac_chL, data_dac_chR, frame_done, busy, overrun, overrun_cnt
  );
  modport slave (
    output lrck_dac, enable, step_l, step_r, rom_q,
    input  rom_addr, data_dac_chL, data_dac_chR, frame_done, busy, overrun, overrun_cnt
  );
`else
  modport master (
    input  lrck_dac, enable, step_l, step_r, rom_q,
    output rom_addr, data_dac_chL, data_dac_chR, frame_done, busy, overrun
  );
  modport slave (
    output lrck_dac, enable, step_l, step_r, rom_q,
    input  rom_addr, data_dac_chL, data_dac_chR, frame_done, busy, overrun
  );
`endif
endinterface

// File: rtl/audio_rom_scheduler.sv
// Time-shares one waveform ROM between L (table 0) and R (table 1) once per lrck frame.
// Define OVERRUN_CNT_EN to add a saturating 8-bit dropped-tick counter.
module audio_rom_scheduler #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 24,
  parameter int ACC_W   = 16,
  parameter int ROM_LAT = 1
) (
  input logic                   clk,
  input logic                   rst,
  audio_rom_scheduler_if.master bus
);
  localparam int CNT_W = (ROM_LAT < 1) ? 1 : $clog2(ROM_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADV,
    S_RD_L,
    S_RD_R,
    S_UPD
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [2:0]        r_lrck_sync;
  logic              w_tick;
  logic              w_start;
  logic              w_drop;
  logic              w_cnt_last;

  logic [CNT_W-1:0]  r_cnt;
  logic [ACC_W-1:0]  r_step_l;
  logic [ACC_W-1:0]  r_step_r;
  logic [ACC_W-1:0]  r_acc_l;
  logic [ACC_W-1:0]  r_acc_r;
  logic [ACC_W-1:0]  w_acc_l_sum;
  logic [ACC_W-1:0]  w_acc_r_sum;
  logic [ADDR_W:0]   r_rom_addr;
  logic [DATA_W-1:0] r_hold_l;
  logic [DATA_W-1:0] r_hold_r;
  logic [DATA_W-1:0] r_dac_l;
  logic [DATA_W-1:0] r_dac_r;
  logic              r_frame_done;
  logic              r_overrun;

  // Two metastability flops plus one delay flop; tick marks the synchronised rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lrck_sync <= 3'b000;
    end else begin
      r_lrck_sync <= {r_lrck_sync[1:0], bus.lrck_dac};
    end
  end

  assign w_tick      = r_lrck_sync[1] & ~r_lrck_sync[2];
  assign w_start     = w_tick & bus.enable & (r_state == S_IDLE);
  assign w_drop      = w_tick & bus.enable & (r_state != S_IDLE);
  assign w_cnt_last  = (r_cnt == CNT_W'(ROM_LAT));
  assign w_acc_l_sum = r_acc_l + r_step_l;
  assign w_acc_r_sum = r_acc_r + r_step_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_next = S_ADV;
      S_ADV:   w_state_next = S_RD_L;
      S_RD_L:  if (w_cnt_last) w_state_next = S_RD_R;
      S_RD_R:  if (w_cnt_last) w_state_next = S_UPD;
      S_UPD:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // The ROM address is registered one state ahead so it is stable for every read cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_step_l     <= '0;
      r_step_r     <= '0;
      r_acc_l      <= '0;
      r_acc_r      <= '0;
      r_rom_addr   <= '0;
      r_hold_l     <= '0;
      r_hold_r     <= '0;
      r_dac_l      <= '0;
      r_dac_r      <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_step_l <= bus.step_l;
            r_step_r <= bus.step_r;
          end
        end
        S_ADV: begin
          r_acc_l    <= w_acc_l_sum;
          r_acc_r    <= w_acc_r_sum;
          r_rom_addr <= {1'b0, w_acc_l_sum[ACC_W-1 -: ADDR_W]};
          r_cnt      <= '0;
        end
        S_RD_L: begin
          if (w_cnt_last) begin
            r_hold_l   <= bus.rom_q;
            r_rom_addr <= {1'b1, r_acc_r[ACC_W-1 -: ADDR_W]};
            r_cnt      <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RD_R: begin
          if (w_cnt_last) begin
            r_hold_r <= bus.rom_q;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_UPD: begin
          r_dac_l      <= r_hold_l;
          r_dac_r      <= r_hold_r;
          r_frame_done <= 1'b1;
        end
        default: begin
        end
      endcase
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

`ifdef OVERRUN_CNT_EN
  logic [7:0] r_overrun_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun_cnt <= 8'h00;
    end else if (w_drop && (r_overrun_cnt != 8'hFF)) begin
      r_overrun_cnt <= r_overrun_cnt + 8'h01;
    end
  end

  assign bus.overrun_cnt = r_overrun_cnt;
`endif

  assign bus.rom_addr     = r_rom_addr;
  assign bus.data_dac_chL = r_dac_l;
  assign bus.data_dac_chR = r_dac_r;
  assign bus.frame_done   = r_frame_done;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.overrun      = r_overrun;

endmodule

// File: tb/tb_audio_rom_scheduler.sv
// Self-checking bench for audio_rom_scheduler: address-echo ROM, random steps, frame-level model.
// Build with OVERRUN_CNT_EN defined to also exercise the dropped-tick counter.
module tb_audio_rom_scheduler #(
  parameter int ROM_LAT = 1
);
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 24;
  localparam int ACC_W     = 16;
  localparam int LAT_EDGES = 2 * ROM_LAT + 7;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   m_acc_l;
  int   m_acc_r;

  audio_rom_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  audio_rom_scheduler #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .ROM_LAT(ROM_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: each word holds its own address, delivered ROM_LAT clocks later.
  logic [ADDR_W:0] rom_pipe [ROM_LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= bus.rom_addr;
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign bus.rom_q = {{(DATA_W - ADDR_W - 1){1'b0}}, rom_pipe[ROM_LAT-1]};

  function automatic logic [31:0] exp_l(input int acc);
    return 32'((acc >> (ACC_W - ADDR_W)) % (1 << ADDR_W));
  endfunction

  function automatic logic [31:0] exp_r(input int acc);
    return 32'((1 << ADDR_W) + (acc >> (ACC_W - ADDR_W)) % (1 << ADDR_W));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives lrck from a per-cycle pattern and tallies frame_done/busy after each edge.
  task automatic drive(input int n, input logic [63:0] pat,
                       output int first_done, output int n_done, output int n_busy);
    first_done = 0;
    n_done     = 0;
    n_busy     = 0;
    for (int i = 0; i < n; i++) begin
      bus.lrck_dac = pat[i];
      @(posedge clk);
      #1;
      if (bus.frame_done) begin
        n_done++;
        if (first_done == 0) first_done = i + 1;
      end
      if (bus.busy) n_busy++;
    end
    bus.lrck_dac = 1'b0;
  endtask

  task automatic do_frame(input logic [15:0] sl, input logic [15:0] sr);
    int fd, nd, nb;
    bus.step_l = sl;
    bus.step_r = sr;
    drive(24, 64'hF, fd, nd, nb);
    m_acc_l = (m_acc_l + int'(sl)) % 65536;
    m_acc_r = (m_acc_r + int'(sr)) % 65536;
    check("latency", 32'(fd), 32'(LAT_EDGES));
    check("done_count", 32'(nd), 32'd1);
    check("chL", 32'(bus.data_dac_chL), exp_l(m_acc_l));
    check("chR", 32'(bus.data_dac_chR), exp_r(m_acc_r));
    check("rom_addr_hold", 32'(bus.rom_addr), exp_r(m_acc_r));
    $display("[TB] frame step_l=%h step_r=%h chL=%h chR=%h lat=%0d",
             sl, sr, bus.data_dac_chL, bus.data_dac_chR, fd);
  endtask

  initial begin
    int fd, nd, nb;
    tests        = 0;
    fails        = 0;
    m_acc_l      = 0;
    m_acc_r      = 0;
    rst          = 1'b1;
    bus.lrck_dac = 1'b0;
    bus.enable   = 1'b0;
    bus.step_l   = '0;
    bus.step_r   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_chL", 32'(bus.data_dac_chL), 32'd0);
    check("rst_chR", 32'(bus.data_dac_chR), 32'd0);
    check("rst_done", 32'(bus.frame_done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Directed first frame, then random steps including a zero step.
    bus.enable = 1'b1;
    do_frame(16'h0100, 16'h0300);
    check("first_chL", 32'(bus.data_dac_chL), 32'h000001);
    check("first_chR", 32'(bus.data_dac_chR), 32'h000103);
    for (int k = 0; k < 8; k++) begin
      do_frame(16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)));
    end
    do_frame(16'h0000, 16'h0000);
    check("overrun_idle", 32'(bus.overrun), 32'd0);

    // Ticks while disabled change nothing.
    bus.enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.step_l = 16'($urandom_range(1, 16'hFFFF));
      bus.step_r = 16'($urandom_range(1, 16'hFFFF));
      drive(24, 64'hF, fd, nd, nb);
      check("gated_done", 32'(nd), 32'd0);
      check("gated_busy", 32'(nb), 32'd0);
      check("gated_chL", 32'(bus.data_dac_chL), exp_l(m_acc_l));
      check("gated_chR", 32'(bus.data_dac_chR), exp_r(m_acc_r));
    end
    bus.enable = 1'b1;
    do_frame(16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)));

    // enable dropped while in ADV: the frame still completes.
    bus.step_l   = 16'h1234;
    bus.step_r   = 16'h4321;
    bus.lrck_dac = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.enable = 1'b0;
    drive(24, 64'h0, fd, nd, nb);
    m_acc_l = (m_acc_l + 32'h1234) % 65536;
    m_acc_r = (m_acc_r + 32'h4321) % 65536;
    check("en_drop_done", 32'(nd), 32'd1);
    check("en_drop_chL", 32'(bus.data_dac_chL), exp_l(m_acc_l));
    check("en_drop_chR", 32'(bus.data_dac_chR), exp_r(m_acc_r));
    $display("[TB] enable-drop frame chL=%h chR=%h", bus.data_dac_chL, bus.data_dac_chR);
    bus.enable = 1'b1;

    // Second lrck edge 4 clk after the first tick is dropped.
    bus.step_l = 16'h0700;
    bus.step_r = 16'h0900;
    drive(24, 64'hF3, fd, nd, nb);
    m_acc_l = (m_acc_l + 32'h0700) % 65536;
    m_acc_r = (m_acc_r + 32'h0900) % 65536;
    check("ovr_flag", 32'(bus.overrun), 32'd1);
    check("ovr_done_count", 32'(nd), 32'd1);
    check("ovr_latency", 32'(fd), 32'(LAT_EDGES));
    check("ovr_chL", 32'(bus.data_dac_chL), exp_l(m_acc_l));
    check("ovr_chR", 32'(bus.data_dac_chR), exp_r(m_acc_r));
`ifdef OVERRUN_CNT_EN
    check("ovr_cnt_one", 32'(bus.overrun_cnt), 32'd1);
`endif
    $display("[TB] overrun frame overrun=%0d done_count=%0d", bus.overrun, nd);

    // Asynchronous reset in the middle of RD_L.
    bus.lrck_dac = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("mid_busy", 32'(bus.busy), 32'd1);
    bus.lrck_dac = 1'b0;
    rst = 1'b1;
    #1;
    check("async_chL", 32'(bus.data_dac_chL), 32'd0);
    check("async_chR", 32'(bus.data_dac_chR), 32'd0);
    check("async_busy", 32'(bus.busy), 32'd0);
    check("async_done", 32'(bus.frame_done), 32'd0);
    check("async_overrun", 32'(bus.overrun), 32'd0);
    check("async_rom_addr", 32'(bus.rom_addr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_acc_l = 0;
    m_acc_r = 0;
    drive(20, 64'h0, fd, nd, nb);
    check("post_rst_done", 32'(nd), 32'd0);
    $display("[TB] reset mid-frame, no frame_done afterwards=%0d", nd);

    // Accumulator wrap: 255 frames to index 0xFF, then one more step.
    for (int k = 0; k < 255; k++) do_frame(16'h0100, 16'h0100);
    check("preload_chL", 32'(bus.data_dac_chL), 32'h0000FF);
    do_frame(16'h0100, 16'h0200);
    check("wrap_chL", 32'(bus.data_dac_chL), 32'h000000);
    check("wrap_chR", 32'(bus.data_dac_chR), 32'h000101);

`ifdef OVERRUN_CNT_EN
    // Fast lrck toggling forces hundreds of drops; the counter must saturate.
    for (int k = 0; k < 30; k++) drive(64, 64'h5555_5555_5555_5555, fd, nd, nb);
    drive(24, 64'h0, fd, nd, nb);
    check("ovr_cnt_sat", 32'(bus.overrun_cnt), 32'hFF);
    check("ovr_flag_sat", 32'(bus.overrun), 32'd1);
    $display("[TB] saturation overrun_cnt=%h", bus.overrun_cnt);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
